// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_seq_defines (package)
// Description : Shared types and cause codes for the cpu_seq control
//               sequencer: state encoding, halt/trap cause enumerations.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_seq_defines;

    localparam int unsigned c_STATE_W = 3;
    localparam int unsigned c_CAUSE_W = 2;

    // Cause codes, shared by the enums below and by software-visible status.
    localparam logic [c_CAUSE_W-1:0] c_HALT_NONE   = 2'd0;
    localparam logic [c_CAUSE_W-1:0] c_HALT_EBREAK = 2'd1;
    localparam logic [c_CAUSE_W-1:0] c_HALT_DEBUG  = 2'd2;
    localparam logic [c_CAUSE_W-1:0] c_HALT_STEP   = 2'd3;

    localparam logic [c_CAUSE_W-1:0] c_TRAP_NONE   = 2'd0;
    localparam logic [c_CAUSE_W-1:0] c_TRAP_IFU    = 2'd1;
    localparam logic [c_CAUSE_W-1:0] c_TRAP_LSU    = 2'd2;
    localparam logic [c_CAUSE_W-1:0] c_TRAP_EXU    = 2'd3;

    typedef enum logic [c_STATE_W-1:0] {
        RESET = 3'd0,
        START = 3'd1,
        FETCH = 3'd2,
        MEM   = 3'd3,
        EXEC  = 3'd4,
        HALT  = 3'd5,
        TRAP  = 3'd6
    } cpu_seq_state;

    typedef enum logic [c_CAUSE_W-1:0] {
        HC_NONE   = c_HALT_NONE,
        HC_EBREAK = c_HALT_EBREAK,
        HC_DEBUG  = c_HALT_DEBUG,
        HC_STEP   = c_HALT_STEP
    } halt_cause_e;

    typedef enum logic [c_CAUSE_W-1:0] {
        TC_NONE = c_TRAP_NONE,
        TC_IFU  = c_TRAP_IFU,
        TC_LSU  = c_TRAP_LSU,
        TC_EXU  = c_TRAP_EXU
    } trap_cause_e;

endpackage : cpu_seq_defines
`default_nettype wire

// File: rtl/cpu_seq_stall_timer.sv
`default_nettype none
// ============================================================================
// Module      : stall_timer
// Description : Saturating per-stage stall counter with expiry flag.
//               o_expire is high while the count equals TIMEOUT-1, i.e. in
//               the last cycle a response may still arrive. TIMEOUT=0 never
//               expires; the counter then just saturates.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clear       - restart the count at zero (stage entry)
//               i_count_en    - one more cycle spent waiting
//               o_expire      - stage has used its full budget
// Revision    : 1.0 - initial release
// ============================================================================
module stall_timer #(
    parameter int unsigned TIMEOUT   = 256,
    parameter int unsigned TIMEOUT_W = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expire
);

    localparam int unsigned            c_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TIMEOUT_W-1:0]   c_LAST   = TIMEOUT_W'(c_LAST_I);
    localparam logic [TIMEOUT_W-1:0]   c_MAX    = {TIMEOUT_W{1'b1}};

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != c_MAX)) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

    assign o_expire = (TIMEOUT != 0) && (r_count == c_LAST);

endmodule : stall_timer
`default_nettype wire

// File: rtl/cpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : cpu_seq
// Description : Multi-cycle control sequencer. Walks one instruction at a
//               time through IFU -> (LSU) -> EXU request/response handshakes,
//               counts retired instructions, traps on hung stages and
//               supports debug halt / resume / single-step.
// Ports       : clock, reset                   - clock, sync active-high reset
//               ifu_reqValid / ifu_respValid   - fetch handshake
//               is_load_or_store               - route to LSU (with ifu_resp)
//               lsu_reqValid / lsu_respValid   - memory handshake
//               exu_reqValid / exu_respValid   - execute handshake
//               is_ebreak                      - ebreak (with exu_resp)
//               dbg_halt_req/dbg_resume_req/dbg_step - debug control
//               halted, halt_cause             - halt status
//               trap, trap_cause               - trap status
//               instret                        - retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq #(
    parameter int unsigned TIMEOUT      = 256,
    parameter int unsigned TIMEOUT_W    = 9,
    parameter int unsigned CNT_W        = 64,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    output logic             ifu_reqValid,
    input  logic             ifu_respValid,
    input  logic             is_load_or_store,
    output logic             lsu_reqValid,
    input  logic             lsu_respValid,
    output logic             exu_reqValid,
    input  logic             exu_respValid,
    input  logic             is_ebreak,
    input  logic             dbg_halt_req,
    input  logic             dbg_resume_req,
    input  logic             dbg_step,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    import cpu_seq_defines::*;

    cpu_seq_state      r_state, w_next;
    halt_cause_e       r_halt_cause, w_halt_cause_nxt;
    trap_cause_e       r_trap_cause, w_trap_cause_nxt;
    logic [CNT_W-1:0]  r_instret;
    logic              r_halt_pending;
    logic              r_step_mode;

    logic w_ifu_req, w_lsu_req, w_exu_req;
    logic w_retire, w_enter_halt, w_resume;
    logic w_tmr_clear, w_tmr_count, w_tmr_expire;

    // Every entry into FETCH/MEM/EXEC is accompanied by its request pulse,
    // so the request itself is the timer restart.
    assign w_tmr_clear = w_ifu_req | w_lsu_req | w_exu_req;

    stall_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_stall_timer (
        .clk        (clock),
        .rst        (reset),
        .i_clear    (w_tmr_clear),
        .i_count_en (w_tmr_count),
        .o_expire   (w_tmr_expire)
    );

    always_comb begin
        w_next           = r_state;
        w_ifu_req        = 1'b0;
        w_lsu_req        = 1'b0;
        w_exu_req        = 1'b0;
        w_retire         = 1'b0;
        w_enter_halt     = 1'b0;
        w_resume         = 1'b0;
        w_tmr_count      = 1'b0;
        w_halt_cause_nxt = r_halt_cause;
        w_trap_cause_nxt = r_trap_cause;

        case (r_state)
            RESET: begin
                if (RESET_HALTED) begin
                    w_next           = HALT;
                    w_halt_cause_nxt = HC_DEBUG;
                    w_enter_halt     = 1'b1;
                end else begin
                    w_next = START;
                end
            end

            START: begin
                w_ifu_req = 1'b1;
                w_next    = FETCH;
            end

            FETCH: begin
                if (ifu_respValid) begin
                    if (is_load_or_store) begin
                        w_lsu_req = 1'b1;
                        w_next    = MEM;
                    end else begin
                        w_exu_req = 1'b1;
                        w_next    = EXEC;
                    end
                end else if (w_tmr_expire) begin
                    w_next           = TRAP;
                    w_trap_cause_nxt = TC_IFU;
                end else begin
                    w_tmr_count = 1'b1;
                end
            end

            MEM: begin
                if (lsu_respValid) begin
                    w_exu_req = 1'b1;
                    w_next    = EXEC;
                end else if (w_tmr_expire) begin
                    w_next           = TRAP;
                    w_trap_cause_nxt = TC_LSU;
                end else begin
                    w_tmr_count = 1'b1;
                end
            end

            EXEC: begin
                if (exu_respValid) begin
                    w_retire = 1'b1;
                    // Instruction boundary: the only place a halt can land.
                    if (is_ebreak) begin
                        w_next           = HALT;
                        w_halt_cause_nxt = HC_EBREAK;
                        w_enter_halt     = 1'b1;
                    end else if (r_halt_pending) begin
                        w_next           = HALT;
                        w_halt_cause_nxt = HC_DEBUG;
                        w_enter_halt     = 1'b1;
                    end else if (r_step_mode) begin
                        w_next           = HALT;
                        w_halt_cause_nxt = HC_STEP;
                        w_enter_halt     = 1'b1;
                    end else begin
                        w_ifu_req = 1'b1;
                        w_next    = FETCH;
                    end
                end else if (w_tmr_expire) begin
                    w_next           = TRAP;
                    w_trap_cause_nxt = TC_EXU;
                end else begin
                    w_tmr_count = 1'b1;
                end
            end

            HALT: begin
                // A simultaneous halt request keeps the core parked.
                if (dbg_resume_req && !dbg_halt_req) begin
                    w_ifu_req = 1'b1;
                    w_resume  = 1'b1;
                    w_next    = FETCH;
                end
            end

            TRAP: begin
                w_next = TRAP;
            end

            default: begin
                w_next = RESET;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= RESET;
            r_instret      <= '0;
            r_halt_pending <= 1'b0;
            r_step_mode    <= 1'b0;
            r_halt_cause   <= HC_NONE;
            r_trap_cause   <= TC_NONE;
        end else begin
            r_state      <= w_next;
            r_halt_cause <= w_halt_cause_nxt;
            r_trap_cause <= w_trap_cause_nxt;

            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end

            if (w_resume) begin
                r_halt_pending <= 1'b0;
            end else if (dbg_halt_req && (r_state != HALT) && (r_state != TRAP)) begin
                r_halt_pending <= 1'b1;
            end

            if (w_enter_halt) begin
                r_step_mode <= 1'b0;
            end else if (w_resume) begin
                r_step_mode <= dbg_step;
            end
        end
    end

    assign ifu_reqValid = w_ifu_req;
    assign lsu_reqValid = w_lsu_req;
    assign exu_reqValid = w_exu_req;
    assign halted       = (r_state == HALT);
    assign trap         = (r_state == TRAP);
    assign halt_cause   = r_halt_cause;
    assign trap_cause   = r_trap_cause;
    assign instret      = r_instret;

    // Readable state name for debug inspection in simulation.
    function automatic string state_name(input cpu_seq_state s);
        case (s)
            RESET:   return "RESET";
            START:   return "START";
            FETCH:   return "FETCH";
            MEM:     return "MEM";
            EXEC:    return "EXEC";
            HALT:    return "HALT";
            TRAP:    return "TRAP";
            default: return "?";
        endcase
    endfunction

endmodule : cpu_seq
`default_nettype wire

// File: tb/tb_cpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_seq
// Description : Self-checking bench for cpu_seq. Instance A (TIMEOUT=8)
//               runs the instruction table, debug and watchdog sequences;
//               instance B (RESET_HALTED=1) covers start-halted and
//               mid-fetch reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_seq;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, b_reset;
    logic ifu_resp, is_ls, lsu_resp, exu_resp, is_ebreak;
    logic dbg_halt_req, dbg_resume_req, dbg_step, b_resume;

    logic        a_ifu_req, a_lsu_req, a_exu_req, a_halted, a_trap;
    logic [1:0]  a_halt_cause, a_trap_cause;
    logic [63:0] a_instret;
    logic        b_ifu_req, b_lsu_req, b_exu_req, b_halted, b_trap;
    logic [1:0]  b_halt_cause, b_trap_cause;
    logic [63:0] b_instret;

    cpu_seq #(.TIMEOUT(8), .TIMEOUT_W(4), .CNT_W(64), .RESET_HALTED(1'b0)) dut_a (
        .clock(clock), .reset(reset),
        .ifu_reqValid(a_ifu_req), .ifu_respValid(ifu_resp), .is_load_or_store(is_ls),
        .lsu_reqValid(a_lsu_req), .lsu_respValid(lsu_resp),
        .exu_reqValid(a_exu_req), .exu_respValid(exu_resp), .is_ebreak(is_ebreak),
        .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req), .dbg_step(dbg_step),
        .halted(a_halted), .halt_cause(a_halt_cause), .trap(a_trap), .trap_cause(a_trap_cause),
        .instret(a_instret)
    );

    cpu_seq #(.TIMEOUT(256), .TIMEOUT_W(9), .CNT_W(64), .RESET_HALTED(1'b1)) dut_b (
        .clock(clock), .reset(b_reset),
        .ifu_reqValid(b_ifu_req), .ifu_respValid(ifu_resp), .is_load_or_store(is_ls),
        .lsu_reqValid(b_lsu_req), .lsu_respValid(lsu_resp),
        .exu_reqValid(b_exu_req), .exu_respValid(exu_resp), .is_ebreak(is_ebreak),
        .dbg_halt_req(1'b0), .dbg_resume_req(b_resume), .dbg_step(1'b0),
        .halted(b_halted), .halt_cause(b_halt_cause), .trap(b_trap), .trap_cause(b_trap_cause),
        .instret(b_instret)
    );

    int total = 0;
    int bad   = 0;
    int n_ifu = 0, n_lsu = 0, n_exu = 0;

    // Request pulse counters for instance A, sampled mid-cycle.
    always @(negedge clock) begin
        if (a_ifu_req) n_ifu++;
        if (a_lsu_req) n_lsu++;
        if (a_exu_req) n_exu++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        int ifu_lat;
        bit ls;
        int lsu_lat;
        int exu_lat;
        bit ebreak;
        bit halt_mem;
        int exp_ifu;
        int exp_lsu;
        int exp_cause;
    } vec_t;

    typedef struct {
        logic [63:0] instret;
        logic        halted;
        logic [1:0]  cause;
    } sb_t;

    sb_t         sbq[$];
    logic [63:0] model_instret = 0;
    logic [1:0]  model_hc      = 0;
    vec_t        vecs[14];

    // Entry: first cycle in FETCH (posedge+1). Exit: first cycle of the
    // following state (FETCH or HALT).
    task automatic run_instr(input vec_t v, input string tag);
        int  i0, l0, e0;
        sb_t e, s;
        i0 = n_ifu; l0 = n_lsu; e0 = n_exu;
        for (int k = 1; k < v.ifu_lat; k++) tick();
        ifu_resp = 1'b1; is_ls = v.ls;
        @(negedge clock);
        check({tag, ".route"}, {a_lsu_req, a_exu_req}, v.ls ? 2'b10 : 2'b01);
        tick();
        ifu_resp = 1'b0; is_ls = 1'b0;
        if (v.ls) begin
            if (v.halt_mem) dbg_halt_req = 1'b1;
            for (int k = 1; k < v.lsu_lat; k++) begin
                tick();
                dbg_halt_req = 1'b0;
            end
            lsu_resp = 1'b1;
            @(negedge clock);
            check({tag, ".mem_exu_req"}, a_exu_req, 1'b1);
            tick();
            lsu_resp = 1'b0; dbg_halt_req = 1'b0;
        end
        for (int k = 1; k < v.exu_lat; k++) tick();
        exu_resp = 1'b1; is_ebreak = v.ebreak;
        model_instret = model_instret + 1;
        if (v.exp_cause != 0) model_hc = 2'(v.exp_cause);
        e.instret = model_instret;
        e.halted  = (v.exp_cause != 0);
        e.cause   = model_hc;
        sbq.push_back(e);
        tick();
        exu_resp = 1'b0; is_ebreak = 1'b0;
        s = sbq.pop_front();
        check({tag, ".instret"}, a_instret, s.instret);
        check({tag, ".halted"}, a_halted, s.halted);
        check({tag, ".halt_cause"}, a_halt_cause, s.cause);
        check({tag, ".ifu_pulses"}, n_ifu - i0, v.exp_ifu);
        check({tag, ".lsu_pulses"}, n_lsu - l0, v.exp_lsu);
        check({tag, ".exu_pulses"}, n_exu - e0, 1);
    endtask

    // Entry/exit: in HALT / in FETCH, at posedge+1.
    task automatic resume(input bit step, input string tag);
        dbg_resume_req = 1'b1; dbg_step = step;
        @(negedge clock);
        check({tag, ".resume_ifu_req"}, a_ifu_req, 1'b1);
        tick();
        dbg_resume_req = 1'b0; dbg_step = 1'b0;
        check({tag, ".resumed"}, a_halted, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; b_reset = 1'b1;
        ifu_resp = 0; is_ls = 0; lsu_resp = 0; exu_resp = 0; is_ebreak = 0;
        dbg_halt_req = 0; dbg_resume_req = 0; dbg_step = 0; b_resume = 0;

        // ifu_lat ls lsu_lat exu_lat ebreak halt_mem | exp_ifu exp_lsu exp_cause
        for (int i = 0; i < 10; i++) vecs[i] = '{2, 0, 0, 1, 0, 0, 1, 0, 0};
        vecs[10] = '{1, 1, 5, 3, 0, 0, 1, 1, 0};
        vecs[11] = '{8, 1, 8, 8, 0, 0, 1, 1, 0};   // responses in expiry cycle
        vecs[12] = '{8, 0, 0, 8, 0, 0, 1, 0, 0};
        vecs[13] = '{1, 1, 3, 2, 0, 1, 0, 1, 2};   // halt request during MEM

        repeat (3) tick();
        @(negedge clock);
        check("rst.reqs", {a_ifu_req, a_lsu_req, a_exu_req}, 3'b000);
        check("rst.halted", a_halted, 1'b0);
        check("rst.trap", a_trap, 1'b0);
        check("rst.causes", {a_halt_cause, a_trap_cause}, 4'd0);
        check("rst.instret", a_instret, 64'd0);
        check("rst_b.halted", b_halted, 1'b0);

        tick();
        reset = 1'b0;
        tick();                               // START
        @(negedge clock);
        check("start.ifu_req", a_ifu_req, 1'b1);
        tick();                               // FETCH

        for (int i = 0; i < 14; i++) begin
            run_instr(vecs[i], $sformatf("vec%0d", i));
            if (i == 9) begin
                check("alu10.ifu_total", n_ifu, 11);
                check("alu10.lsu_total", n_lsu, 0);
            end
        end

        // Resume racing a halt request: stays halted.
        dbg_resume_req = 1'b1; dbg_halt_req = 1'b1;
        @(negedge clock);
        check("race.ifu_req", a_ifu_req, 1'b0);
        tick();
        dbg_resume_req = 1'b0; dbg_halt_req = 1'b0;
        check("race.halted", a_halted, 1'b1);

        resume(1'b1, "step");
        run_instr('{1, 0, 0, 1, 0, 0, 0, 0, 3}, "step_instr");
        resume(1'b0, "res1");
        run_instr('{2, 0, 0, 2, 1, 0, 0, 0, 1}, "ebreak");
        resume(1'b0, "res2");
        run_instr('{1, 0, 0, 1, 0, 0, 1, 0, 0}, "after_ebreak");

        // LSU never answers: trap in the 9th cycle after lsu_reqValid.
        ifu_resp = 1'b1; is_ls = 1'b1;
        @(negedge clock);
        check("wd.lsu_req", a_lsu_req, 1'b1);
        tick();
        ifu_resp = 1'b0; is_ls = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin
                @(negedge clock);
                check("wd.no_trap_yet", a_trap, 1'b0);
            end
            tick();
        end
        @(negedge clock);
        check("wd.trap", a_trap, 1'b1);
        check("wd.trap_cause", a_trap_cause, 2'd2);
        lsu_resp = 1'b1;
        repeat (4) tick();
        lsu_resp = 1'b0;
        @(negedge clock);
        check("wd.stuck", {a_trap, a_ifu_req, a_lsu_req, a_exu_req}, 4'b1000);
        check("wd.instret", a_instret, model_instret);

        // Instance B: start halted, retire one, reset mid-fetch.
        tick();
        b_reset = 1'b0;
        @(negedge clock);
        check("b.reset_state_halted", b_halted, 1'b0);
        tick();
        check("b.halted", b_halted, 1'b1);
        check("b.halt_cause", b_halt_cause, 2'd2);
        b_resume = 1'b1;
        @(negedge clock);
        check("b.ifu_req", b_ifu_req, 1'b1);
        tick();
        b_resume = 1'b0;
        ifu_resp = 1'b1;
        @(negedge clock);
        check("b.exu_req", b_exu_req, 1'b1);
        tick();
        ifu_resp = 1'b0; exu_resp = 1'b1;
        @(negedge clock);
        check("b.next_fetch", b_ifu_req, 1'b1);
        tick();
        exu_resp = 1'b0;
        check("b.instret", b_instret, 64'd1);
        tick();
        b_reset = 1'b1;
        tick();
        @(negedge clock);
        check("b.rst.instret", b_instret, 64'd0);
        check("b.rst.status", {b_halted, b_trap, b_halt_cause, b_trap_cause}, 6'd0);
        check("b.rst.reqs", {b_ifu_req, b_lsu_req, b_exu_req}, 3'b000);

        // Reset clears A's trap.
        tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        check("a.rst.trap", {a_trap, a_trap_cause}, 3'd0);
        check("a.rst.instret", a_instret, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cpu_seq
`default_nettype wire
